muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file's two read ports, alongside the ALU. It captures `rs1_dout`/`rs2_dout` and the instruction's funct3 on a start pulse, and computes the result over a fixed number of cycles with a radix-2 shift/add or shift/subtract datapath. It then presents the 32-bit value for the register file's `rd_din` with a one-cycle done pulse. The control unit stalls the PC while `busy` is high and asserts `write_enable` on `done`.

## Interface
- No parameters; width fixed at 32 (RV32).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; one clock, reset asynchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  32  rs1 value (dividend / multiplicand).
- `op_b`  in  32  rs2 value (divisor / multiplier).
- `busy`  out  1  high while computing; `start` ignored.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  32  last completed result; held until next completion.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `start`=1 at an edge latches `funct3`, `op_a`, `op_b`, the signed/unsigned flags and operand magnitudes; counter := 0; go to CALC. `start`=0: stay.
- CALC: one radix-2 step per cycle; counter increments 0..31; at counter==31 go to DONE.
- DONE: apply sign correction, register `result`, go to IDLE.
- `start` in CALC or DONE is ignored, not queued.
- Multiply: 64-bit product of operand magnitudes; negated if the effective signs differ (MULH both signed, MULHSU rs1 signed only, MULHU/MUL none). MUL returns low 32 bits; the others return high 32 bits.
- Divide: restoring division on magnitudes. Quotient sign = sign(a) XOR sign(b) for DIV. Remainder sign = sign(a) for REM.
- Divisor zero: quotient = 32'hFFFF_FFFF, remainder = `op_a`. Fixed latency is still spent.
- Signed overflow (a=32'h8000_0000, b=32'hFFFF_FFFF, DIV/REM): quotient = 32'h8000_0000, remainder = 0.
- Reset at any time: state IDLE, counter 0, all internal registers 0.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=32'h0.
- Start sampled at edge E0. `busy`=1 from E0 to E32 (32 CALC cycles).
- DONE entered at E32. `done`=1 and `busy`=0 from E33 to E34, with `result` updated at E33.
- Latency is 33 cycles from the start edge to `result` valid, for every op including the special cases.
- Next `start` is accepted at E34 at the earliest; back-to-back throughput is one op per 34 cycles.
- `op_a`/`op_b`/`funct3` may change freely after E0.
- `reset` asserted mid-CALC: `busy` and `done` drop immediately (asynchronously). No `done` pulse is produced for the aborted op.

## Configuration
- `MULDIV_DIV_EN` defined: all eight funct3 ops implemented as above.
- Not defined: the division datapath and its registers are removed.
  - funct3[2]=1 ops still handshake with identical timing.
  - They return `result` = 32'h0.
  - Multiply behaviour is unchanged.

## Structure
- Shared package `muldiv_pkg` holds:
  - funct3 constants `F3_MUL`..`F3_REMU`;
  - state encoding `ST_IDLE`, `ST_CALC`, `ST_DONE`;
  - `XLEN` = 32 and the iteration count `MULDIV_ITERS` = 32.
- One natural combinational sub-module, `muldiv_sign_prep`, maps (funct3, op_a, op_b) to magnitudes, the negate-result flag and the special-case flags. The FSM and datapath stay in `muldiv_unit`.

## Test plan
- Reset mid-op: start MUL 3×5, assert `reset` at cycle 10 → `busy`=0 and `done`=0 at once; `result`=0; no `done` pulse afterward.
- MUL 7×(-3) (32'hFFFF_FFFD) → `done` 33 cycles after start; `result`=32'hFFFF_FFEB.
- MULH and MULHU with a=b=32'h8000_0000:
  - MULH → 32'h4000_0000;
  - MULHU → 32'h4000_0000;
  - MULHSU(32'hFFFF_FFFF, 2) → 32'hFFFF_FFFF.
- DIV and REM with -7 and 2:
  - DIV → 32'hFFFF_FFFD (-3);
  - REM → 32'hFFFF_FFFF (-1);
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Division special cases:
  - DIV 5/0 → 32'hFFFF_FFFF; REM 5/0 → 5;
  - DIV 32'h8000_0000/32'hFFFF_FFFF → 32'h8000_0000; REM of the same → 0.
- `start` held high continuously across two ops → second op is accepted exactly at E34. Operands changed during CALC do not affect the first `result`.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
// The struct layout depends on MULDIV_DIV_EN: the division special-case
// flags only exist when the divider is built.
package muldiv_pkg;

  localparam int XLEN         = 32;
  localparam int MULDIV_ITERS = 32;

  // RV32M funct3 encodings.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Most negative signed value, the only dividend that can overflow DIV.
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operand preparation result: unsigned magnitudes fed to the datapath,
  // whether the final value must be negated, and division corner cases.
  typedef struct packed {
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            neg;
`ifdef MULDIV_DIV_EN
    logic            div_zero;
    logic            div_ovf;
`endif
  } prep_t;

  // Two's-complement magnitude of v when sgn is set, otherwise v unchanged.
  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v,
                                             input logic            sgn);
    return sgn ? (-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the control unit and muldiv_unit.
//
// Handshake: the master raises start with funct3/op_a/op_b valid; the unit
// samples them at the first rising edge where it is idle, and ignores start
// at every other edge (nothing is queued). busy is high while the op computes.
// done is a one-cycle pulse marking the cycle in which result holds the new
// value; result then holds until the next completion. Operands may change
// freely once the accepting edge has passed.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output busy, done, result
  );

endinterface

// File: rtl/muldiv_sign_prep.sv
// muldiv_sign_prep: combinational operand conditioning for muldiv_unit.
// Decides per funct3 which operands are signed, produces their magnitudes,
// the result-negate flag and (with MULDIV_DIV_EN) the divide-by-zero and
// signed-overflow flags.
module muldiv_sign_prep
  import muldiv_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output prep_t           prep_o
);

  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;

  // Signedness of each operand for the requested op.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_i)
      F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: a_signed = 1'b1;
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase
  end

  assign a_neg = a_signed & op_a_i[XLEN-1];
  assign b_neg = b_signed & op_b_i[XLEN-1];

  // Magnitudes, final sign and division corner cases.
  always_comb begin
    prep_o       = '0;
    prep_o.mag_a = abs_if(op_a_i, a_neg);
    prep_o.mag_b = abs_if(op_b_i, b_neg);
    // A remainder takes the dividend's sign; products and quotients take
    // the XOR of both effective signs.
    prep_o.neg   = (funct3_i == F3_REM) ? a_neg : (a_neg ^ b_neg);
`ifdef MULDIV_DIV_EN
    prep_o.div_zero = funct3_i[2] & (op_b_i == '0);
    prep_o.div_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                      (op_a_i == INT_MIN) && (op_b_i == '1);
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
// Radix-2 shift/add multiply and restoring divide on operand magnitudes,
// one step per cycle for 32 cycles, sign fix-up in a final DONE cycle.
// Start-to-result latency is 33 cycles; start-to-start is 34 cycles.
// Build option MULDIV_DIV_EN adds the divider; without it funct3[2]=1 ops
// keep the same handshake timing and return zero.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus,
  output state_t  dbg_state_o
);

  localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITERS - 1);

  // Control state and registered outputs.
  state_t          state_q;
  logic [4:0]      cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  // Op captured at the accepting edge.
  logic [2:0]      f3_q;
  logic            neg_q;

  // Multiplier: {upper accumulator, multiplier bits still to consume}.
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   mcand_q;

  prep_t             prep;
  logic              accept;
  logic              calc;
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   res_d;

  muldiv_sign_prep u_prep (
    .funct3_i (bus.funct3),
    .op_a_i   (bus.op_a),
    .op_b_i   (bus.op_b),
    .prep_o   (prep)
  );

  assign accept = (state_q == ST_IDLE) && bus.start;
  assign calc   = (state_q == ST_CALC);

  // Shift/add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole product right.
  assign mul_addend = prod_q[0] ? mcand_q : {XLEN{1'b0}};
  assign mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};

  // Multiply datapath and captured op fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q  <= '0;
      mcand_q <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
    end else if (accept) begin
      prod_q  <= {{XLEN{1'b0}}, prep.mag_b};
      mcand_q <= prep.mag_a;
      f3_q    <= bus.funct3;
      neg_q   <= prep.neg;
    end else if (calc) begin
      prod_q  <= {mul_sum, prod_q[XLEN-1:1]};
    end
  end

`ifdef MULDIV_DIV_EN
  // Divider: partial remainder, dividend/quotient shift register, divisor.
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic            div_zero_q;
  logic            div_ovf_q;

  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // Restoring step: bring down the next dividend bit and keep the
  // subtraction only if it did not go negative. Since the partial
  // remainder stays below the divisor, bit XLEN of the trial is its sign.
  assign div_shift = {rem_q, quo_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, dvsr_q};

  // Divide datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
    end else if (accept) begin
      rem_q      <= '0;
      quo_q      <= prep.mag_a;
      dvsr_q     <= prep.mag_b;
      div_zero_q <= prep.div_zero;
      div_ovf_q  <= prep.div_ovf;
    end else if (calc) begin
      if (!div_trial[XLEN]) begin
        rem_q <= div_trial[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= div_shift[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end
`endif

  // Final value: sign-correct the magnitude result and pick the word.
  always_comb begin
    prod_fix = neg_q ? (-prod_q) : prod_q;
    mul_res  = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    // With a zero divisor every trial succeeds, so the remainder register
    // ends up holding |op_a|; re-applying the dividend sign yields op_a.
    if (div_zero_q) begin
      quo_fix = '1;
    end else if (div_ovf_q) begin
      quo_fix = INT_MIN;
    end else begin
      quo_fix = neg_q ? (-quo_q) : quo_q;
    end
    if (div_ovf_q) begin
      rem_fix = '0;
    end else begin
      rem_fix = neg_q ? (-rem_q) : rem_q;
    end
    res_d = f3_q[2] ? (f3_q[1] ? rem_fix : quo_fix) : mul_res;
`else
    res_d = f3_q[2] ? {XLEN{1'b0}} : mul_res;
`endif
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= ST_CALC;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CALC: begin
          if (cnt_q == LAST_ITER) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        ST_DONE: begin
          result_q <= res_d;
          done_q   <= 1'b1;
          cnt_q    <= '0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit. A timeline model of the
// handshake plus an arithmetic reference for each funct3 is checked every
// cycle; each directed vector also carries a hand-computed literal.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic   clk;
  logic   reset;
  state_t dbg_state;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic        [63:0] p;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (f3[2] && !DIV_EN) return 32'h0;
    case (f3)
      F3_MUL: begin
        p = {32'h0, a} * {32'h0, b};
        return p[31:0];
      end
      F3_MULH: begin
        sx = {{32{a[31]}}, a};
        sy = {{32{b[31]}}, b};
        p  = sx * sy;
        return p[63:32];
      end
      F3_MULHSU: begin
        sx = {{32{a[31]}}, a};
        sy = {32'h0, b};
        p  = sx * sy;
        return p[63:32];
      end
      F3_MULHU: begin
        p = {32'h0, a} * {32'h0, b};
        return p[63:32];
      end
      F3_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      F3_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // ---------------- per-cycle compare process ----------------
  // phase = rising edges since the accepting edge (-1 when idle).
  // busy after edges 0..31, done after edge 33, next accept at 34.
  initial begin : compare
    int          phase;
    logic [31:0] exp_res;
    logic        st;
    logic        rs;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_busy;
    logic        exp_done;
    phase   = -1;
    exp_res = 32'h0;
    forever begin
      @(posedge clk);
      st = bus.start;
      rs = reset;
      f3 = bus.funct3;
      a  = bus.op_a;
      b  = bus.op_b;
      #2;
      if (rs) begin
        phase   = -1;
        exp_res = 32'h0;
        exp_q.delete();
      end else if (phase == -1 || phase >= 33) begin
        if (st) begin
          phase = 0;
          exp_q.push_back(model(f3, a, b));
        end else begin
          phase = -1;
        end
      end else begin
        phase++;
      end
      exp_busy = (phase >= 0 && phase <= 31);
      exp_done = (phase == 33);
      if (exp_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL cyc_exp_q @%0t: got empty queue expected one entry", $time);
        end else begin
          exp_res = exp_q.pop_front();
        end
      end
      chk("cyc_busy", {31'h0, bus.busy}, {31'h0, exp_busy});
      chk("cyc_done", {31'h0, bus.done}, {31'h0, exp_done});
      chk("cyc_result", bus.result, exp_res);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one op from idle, scramble the operands after acceptance, and
  // check latency plus the hand-computed literal.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input string name);
    int          lat;
    logic [31:0] want;
    want = (f3[2] && !DIV_EN) ? 32'h0 : lit;
    chk({name, "_model"}, model(f3, a, b), want);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
    bus.funct3 = 3'($urandom_range(0, 7));
    wait_done(lat);
    chk({name, "_lat"}, 32'(lat), 32'd33);
    chk(name, bus.result, want);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int lat;
    int pulses;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'h0;
    bus.op_b   = 32'h0;

    @(negedge clk);
    #1;
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_op(F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7xm3");
    run_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    run_op(F3_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulhu_min");
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu_m1x2");
    run_op(F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ffxff");
    run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ffxff");
    run_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1xm1");
    run_op(F3_MUL,    32'h1234_5678, 32'd9,         32'hA3D7_0A38, "mul_x9");
    run_op(F3_MULHU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, "mulhu_ffx2");
    run_op(F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2");
    run_op(F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
    run_op(F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
    run_op(F3_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, "rem_7_m2");
    run_op(F3_DIVU,   32'd100,       32'd7,         32'd14,        "divu_100_7");
    run_op(F3_REMU,   32'd100,       32'd7,         32'd2,         "remu_100_7");
    run_op(F3_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, "divu_ff_1");
    run_op(F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, "div_5_0");
    run_op(F3_REM,    32'd5,         32'd0,         32'd5,         "rem_5_0");
    run_op(F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, "divu_5_0");
    run_op(F3_REMU,   32'd5,         32'd0,         32'd5,         "remu_5_0");
    run_op(F3_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem_m7_0");
    run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");

    // start held high across two ops; operands change during the first CALC.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = F3_MUL;
    bus.op_a   = 32'h0001_2345;
    bus.op_b   = 32'h0000_0010;
    @(negedge clk);
    bus.op_a   = 32'h0000_1000;
    bus.op_b   = 32'h0000_1000;
    wait_done(lat);
    chk("b2b_first_lat", 32'(lat), 32'd33);
    chk("b2b_first", bus.result, 32'h0012_3450);
    @(negedge clk);
    chk("b2b_accept_e34", {31'h0, bus.busy}, 32'h1);
    bus.start = 1'b0;
    wait_done(lat);
    chk("b2b_second_lat", 32'(lat), 32'd33);
    chk("b2b_second", bus.result, 32'h0100_0000);

    // Reset in the middle of a MUL: outputs drop at once, no done follows.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = F3_MUL;
    bus.op_a   = 32'd3;
    bus.op_b   = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", {31'h0, bus.busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
    chk("midrst_done", {31'h0, bus.done}, 32'h0);
    chk("midrst_result", bus.result, 32'h0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    chk("midrst_no_done", 32'(pulses), 32'h0);
    chk("midrst_result_hold", bus.result, 32'h0);

    run_op(F3_MUL, 32'd3, 32'd5, 32'd15, "mul_after_rst");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin : watchdog
    #200000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
